booth_product_acc: RTL and testbench

BOOTH_PRODUCT_ACC -- requirements
Module: booth_product_acc

---
 rtl/booth_product_acc.sv | 100 ++++++++++
 tb/tb_booth_product_acc.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_product_acc.sv
// Sums framed signed 32-bit Booth products into an ACC_W-bit total, with a product count and a sticky overflow flag.
// Latency 1 cycle from last beat to out_valid; in_ready low while a result is held. Macro BOOTH_ACC_SAT_EN: clamp on overflow instead of wrapping.
module booth_product_acc #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state, w_state_nxt;
    logic             r_live;
    logic [ACC_W-1:0] r_acc, w_acc_nxt, w_ext, w_sum, w_acc_upd;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             w_beat, w_add_ovf;

    assign w_ext     = {{(ACC_W-32){in_prod[31]}}, in_prod};
    assign w_sum     = r_acc + w_ext;
    assign w_add_ovf = (r_acc[ACC_W-1] == w_ext[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

`ifdef BOOTH_ACC_SAT_EN
    // An overflow can only occur toward the shared operand sign, so that sign picks the rail.
    assign w_acc_upd = w_add_ovf ? (r_acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : w_sum;
`else
    assign w_acc_upd = w_sum;
`endif

    // r_live keeps in_ready low until the first clock edge after reset release.
    assign in_ready  = r_live && (r_state != HOLD);
    assign out_valid = (r_state == HOLD);
    assign w_beat    = in_valid && in_ready;
    assign out_acc   = r_acc;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        if (clr) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_beat) begin
                        w_acc_nxt   = w_acc_upd;
                        w_cnt_nxt   = (&r_cnt) ? r_cnt : r_cnt + CNT_ONE;
                        w_ovf_nxt   = r_ovf | w_add_ovf;
                        w_state_nxt = in_last ? HOLD : ACCUM;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        w_state_nxt = IDLE;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_ovf_nxt   = 1'b0;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end
endmodule

// File: tb/tb_booth_product_acc.sv
// Bench for booth_product_acc: 40-bit and 33-bit instances share stimulus; a scoreboard checks every delivered frame.
module tb_booth_product_acc;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_prod = '0;

    logic        in_ready, out_valid, out_ovf;
    logic [39:0] out_acc;
    logic [7:0]  out_count;
    logic        in_ready33, out_valid33, out_ovf33;
    logic [32:0] out_acc33;
    logic [7:0]  out_count33;

    always #5 clk = ~clk;

    booth_product_acc #(.ACC_W(40), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf));

    booth_product_acc #(.ACC_W(33), .CNT_W(8)) dut33 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready33),
        .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid33), .out_ready(out_ready),
        .out_acc(out_acc33), .out_count(out_count33), .out_ovf(out_ovf33));

    typedef struct {
        longint acc40;
        longint acc33;
        int     cnt;
        bit     ovf40;
        bit     ovf33;
    } exp_t;

    exp_t   sb[$];
    exp_t   e;
    longint m40 = 0, m33 = 0;
    int     mcnt = 0;
    bit     mo40 = 0, mo33 = 0;
    int     errors = 0, checks = 0;

    function automatic void madd(input int w, input longint a, input logic [31:0] p,
                                 output longint r, output bit o);
        longint one, maxv, minv, s;
        one  = 1;
        maxv = (one <<< (w-1)) - 1;
        minv = -(one <<< (w-1));
        s    = a + longint'($signed(p));
        o    = 1'b0;
        if (s > maxv || s < minv) begin
            o = 1'b1;
`ifdef BOOTH_ACC_SAT_EN
            s = (s > maxv) ? maxv : minv;
`else
            s = (s > maxv) ? s - (one <<< w) : s + (one <<< w);
`endif
        end
        r = s;
    endfunction

    task automatic mreset();
        m40 = 0; m33 = 0; mcnt = 0; mo40 = 0; mo33 = 0;
    endtask

    task automatic beat(input logic [31:0] p, input bit last);
        int n;
        longint r;
        bit o;
        n = 0;
        in_valid = 1'b1; in_prod = p; in_last = last;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL beat_accept in_ready=%b required=1", in_ready);
        end else begin
            @(posedge clk);
            madd(40, m40, p, r, o); m40 = r; mo40 = mo40 | o;
            madd(33, m33, p, r, o); m33 = r; mo33 = mo33 | o;
            if (mcnt < 255) mcnt++;
            if (last) begin
                sb.push_back('{m40, m33, mcnt, mo40, mo33});
                mreset();
            end
        end
        #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Scoreboard: compare the oldest expected frame whenever a result handshake is about to happen.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected acc=%h count=%0d", out_acc, out_count);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_acc !== e.acc40[39:0]) begin errors++; $display("FAIL sb_acc40 got=%h exp=%h", out_acc, e.acc40[39:0]); end
                checks++;
                if (out_count !== 8'(e.cnt)) begin errors++; $display("FAIL sb_count got=%0d exp=%0d", out_count, e.cnt); end
                checks++;
                if (out_ovf !== e.ovf40) begin errors++; $display("FAIL sb_ovf40 got=%b exp=%b", out_ovf, e.ovf40); end
                checks++;
                if (out_valid33 !== 1'b1 || out_acc33 !== e.acc33[32:0]) begin
                    errors++; $display("FAIL sb_acc33 valid=%b got=%h exp=%h", out_valid33, out_acc33, e.acc33[32:0]);
                end
                checks++;
                if (out_ovf33 !== e.ovf33 || out_count33 !== 8'(e.cnt)) begin
                    errors++; $display("FAIL sb_ovf33 got=%b/%0d exp=%b/%0d", out_ovf33, out_count33, e.ovf33, e.cnt);
                end
            end
        end
    end

    task automatic test_reset();
        #2;
        checks++;
        if ({in_ready, out_valid, out_ovf} !== 3'b000 || out_acc !== 40'd0 || out_count !== 8'd0) begin
            errors++; $display("FAIL reset_state rdy=%b vld=%b ovf=%b acc=%h cnt=%0d required all zero", in_ready, out_valid, out_ovf, out_acc, out_count);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_release_rdy got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_first_edge_rdy got=%b exp=1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        beat(32'd3, 1'b0);
        beat(-32'sd5, 1'b0);
        beat(32'd7, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_acc !== 40'd5 || out_count !== 8'd3 || out_ovf !== 1'b0) begin
            errors++; $display("FAIL basic_latency vld=%b acc=%h cnt=%0d ovf=%b exp 1/5/3/0", out_valid, out_acc, out_count, out_ovf);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 40'd0 || out_count !== 8'd0) begin
            errors++; $display("FAIL basic_pulse_clear vld=%b acc=%h cnt=%0d exp 0/0/0", out_valid, out_acc, out_count);
        end
    endtask

    task automatic test_single();
        beat(32'h8000_0000, 1'b1);
        checks++;
        if (out_acc !== 40'hFF_8000_0000 || out_count !== 8'd1) begin
            errors++; $display("FAIL single_beat acc=%h cnt=%0d exp ff80000000/1", out_acc, out_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(32'd100, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1);
        in_valid = 1'b1; in_prod = 32'd999; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_acc !== 40'd99 || out_count !== 8'd2) begin
                errors++; $display("FAIL hold_stable cyc=%0d rdy=%b vld=%b acc=%h cnt=%0d exp 0/1/99/2", i, in_ready, out_valid, out_acc, out_count);
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_acc !== 40'd0) begin
            errors++; $display("FAIL hold_release vld=%b rdy=%b acc=%h exp 0/1/0", out_valid, in_ready, out_acc);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        beat(32'd1, 1'b1);
        #4;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_rdy got=%b exp=0", in_ready); end
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF, 1'b0);
        beat(32'h7FFF_FFFF, 1'b1);
        checks++;
`ifdef BOOTH_ACC_SAT_EN
        if (out_ovf33 !== 1'b1 || out_acc33 !== 33'h0_FFFF_FFFF) begin
`else
        if (out_ovf33 !== 1'b1 || out_acc33 !== 33'h1_7FFF_FFFD) begin
`endif
            errors++; $display("FAIL ovf33 ovf=%b acc=%h", out_ovf33, out_acc33);
        end
        checks++;
        if (out_ovf !== 1'b0 || out_acc !== 40'h01_7FFF_FFFD) begin
            errors++; $display("FAIL ovf40_none ovf=%b acc=%h exp 0/017ffffffd", out_ovf, out_acc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_count_sat();
        for (int i = 0; i < 299; i++) beat(32'd1, 1'b0);
        beat(32'd1, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        beat(32'd20, 1'b0);
        beat(32'd30, 1'b0);
        clr = 1'b1; in_valid = 1'b1; in_prod = 32'd50; in_last = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        mreset();
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 40'd0 || out_count !== 8'd0) begin
            errors++; $display("FAIL clr_midframe vld=%b acc=%h cnt=%0d exp 0/0/0", out_valid, out_acc, out_count);
        end
        beat(32'd4, 1'b1);
        checks++;
        if (out_acc !== 40'd4 || out_count !== 8'd1) begin
            errors++; $display("FAIL clr_next_frame acc=%h cnt=%0d exp 4/1", out_acc, out_count);
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        beat(32'd9, 1'b1);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (out_valid !== 1'b0 || out_acc !== 40'd0) begin
            errors++; $display("FAIL clr_hold vld=%b acc=%h exp 0/0", out_valid, out_acc);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset_hold();
        out_ready = 1'b0;
        beat(32'd77, 1'b1);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #0.5;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_acc !== 40'd0) begin
            errors++; $display("FAIL rst_hold_async vld=%b rdy=%b acc=%h exp 0/0/0", out_valid, in_ready, out_acc);
        end
        #0.5;
        rst_n = 1'b1;
        void'(sb.pop_back());
        mreset();
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_hold_release vld=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        beat(32'd10, 1'b1);
        checks++;
        if (out_acc !== 40'd10 || out_count !== 8'd1) begin
            errors++; $display("FAIL rst_hold_next acc=%h cnt=%0d exp 10/1", out_acc, out_count);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_count_sat();
        test_clr();
        test_reset_hold();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain pending=%0d required=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
